dmem_arbiter: RTL

//  Shares the single data memory between two requesters: port 0 (core MEM stage) and

---
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Requester-side bus of the data-memory arbiter. It has two
//               ports (index 0 = core MEM stage, index 1 = secondary master).
//               Each port has a request/grant handshake, a load-response pulse
//               and a shared read-data bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic [1:0]                 req;     // per-port request, held until gnt
  logic [1:0]                 we;      // per-port 1=store, 0=load
  logic [1:0][2:0]            funct3;  // per-port size/sign code
  logic [1:0][DM_ADDRESS-1:0] addr;    // per-port byte address
  logic [1:0][DATA_W-1:0]     wdata;   // per-port store data
  logic [1:0]                 gnt;     // one-cycle acceptance pulse
  logic [1:0]                 rvalid;  // one-cycle load-data-valid pulse
  logic [DATA_W-1:0]          rdata;   // load data, valid with rvalid
  logic                       busy;    // access in flight

  // Requester side
  modport master (
    output req, we, funct3, addr, wdata,
    input  gnt, rvalid, rdata, busy
  );

  // Arbiter side
  modport slave (
    input  req, we, funct3, addr, wdata,
    output gnt, rvalid, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter that shares the single data memory between
//               two requesters. Only one access is in flight at a time. An
//               access is sequenced IDLE -> ACCESS -> (RESP for loads) -> IDLE.
//               The memory control outputs are registered and are non-zero
//               only during ACCESS.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  dmem_arbiter_if.slave              bus,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [DM_ADDRESS-1:0]      mem_a,
  output logic [DATA_W-1:0]          mem_wd,
  output logic [2:0]                 mem_funct3,
  input  wire logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;       // port granted most recently
  logic                   owner_q, owner_d;     // port owning the in-flight access
  logic [1:0]             rvalid_q, rvalid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  // Captured request fields; they double as the registered memory drive.
  // They are zero except during ACCESS.
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [DM_ADDRESS-1:0]  mem_a_q, mem_a_d;
  logic [DATA_W-1:0]      mem_wd_q, mem_wd_d;
  logic [2:0]             mem_funct3_q, mem_funct3_d;

  logic                   any_req;
  logic                   winner;
  logic [1:0]             gnt_w;

  // Pick the winner. A lone request wins outright. A tie goes to the port that
  // did not win last time.
  always_comb begin
    any_req = |bus.req;
    if (bus.req == 2'b11) begin
      winner = ~last_q;
    end else begin
      winner = bus.req[1];
    end
    gnt_w = 2'b00;
    if (reset_n && (state_q == S_IDLE) && any_req) begin
      gnt_w = winner ? 2'b10 : 2'b01;
    end
  end

  // Next-state and next-output logic for the access sequencer
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    rvalid_d     = 2'b00;
    rdata_d      = rdata_q;
    busy_d       = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_a_d      = '0;
    mem_wd_d     = '0;
    mem_funct3_d = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d      = S_ACCESS;
          owner_d      = winner;
          last_d       = winner;
          busy_d       = 1'b1;
          mem_read_d   = ~bus.we[winner];
          mem_write_d  = bus.we[winner];
          mem_a_d      = bus.addr[winner];
          mem_wd_d     = bus.wdata[winner];
          mem_funct3_d = bus.funct3[winner];
        end
      end
      S_ACCESS: begin
        if (mem_read_q) begin
          // A load samples the memory at the end of the access cycle.
          // It then presents the data for one cycle in RESP.
          rdata_d  = mem_rd;
          state_d  = S_RESP;
          busy_d   = 1'b1;
          rvalid_d = owner_q ? 2'b10 : 2'b01;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any access
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      rvalid_q     <= 2'b00;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
      mem_funct3_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
      mem_funct3_q <= mem_funct3_d;
    end
  end

  assign bus.gnt    = gnt_w;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;
  assign mem_funct3 = mem_funct3_q;

endmodule
`default_nettype wire
